// File: rtl/mixcol_iter.sv
// ---------------------------------------------------------------------------
// mixcol_iter
//
// Iterative, handshaked AES MixColumns engine. A 128-bit state is latched on
// accept and transformed in place, COLS_PER_CYCLE columns per clock. It takes
// NSTEP = 4/COLS_PER_CYCLE clocks, then the state is presented until the
// consumer takes it.
//
// Optional build macro:
//   MIXCOL_INV_EN : when defined, in_inv (latched at accept) selects
//                   InvMixColumns. When undefined, the inverse multiplier
//                   logic is absent and in_inv is ignored. The port is kept
//                   so the interface stays the same.
//
// Parameters:
//   COLS_PER_CYCLE : columns transformed per clock (1, 2 or 4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_state/in_inv valid
//   in_ready   block can accept a new state (registered)
//   in_state   128-bit state; column c = [127-32c -: 32], row 0 = MSB byte
//   in_inv     1 = InvMixColumns (only with MIXCOL_INV_EN)
//   out_valid  out_state valid (registered)
//   out_ready  consumer accepts out_state
//   out_state  transformed state, same byte layout as in_state
// ---------------------------------------------------------------------------
module mixcol_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int         NSTEP     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t         fsm_p0;
  logic [1:0]   cnt_p0;
  logic [127:0] data_p0;
  logic [127:0] data_next;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward column: rows [2 3 1 1] [1 2 3 1] [1 1 2 3] [3 1 1 2].
  function automatic logic [31:0] fwd_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m3[i] = m2[i] ^ a[i];
    end
    return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
            a[0]  ^ m2[1] ^ m3[2] ^ a[3],
            a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
            m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_p0;

  // Inverse column: rows [E B D 9] [9 E B D] [D 9 E B] [B D 9 E].
  // The 9/B/D/E multiples are sums of the chained x2, x4, x8 terms.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [31:0] col_xform(input logic [31:0] col, input logic inv);
    return inv ? inv_mix_col(col) : fwd_mix_col(col);
  endfunction
`else
  // in_inv is intentionally not consumed in the forward-only build.
  logic unused_inv;
  assign unused_inv = in_inv;

  function automatic logic [31:0] col_xform(input logic [31:0] col);
    return fwd_mix_col(col);
  endfunction
`endif

  // Columns cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 are rewritten; the rest hold.
  always_comb begin
    data_next = data_p0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIXCOL_INV_EN
      data_next[127 - 32*(int'(cnt_p0)*COLS_PER_CYCLE + k) -: 32] =
        col_xform(data_p0[127 - 32*(int'(cnt_p0)*COLS_PER_CYCLE + k) -: 32], inv_p0);
`else
      data_next[127 - 32*(int'(cnt_p0)*COLS_PER_CYCLE + k) -: 32] =
        col_xform(data_p0[127 - 32*(int'(cnt_p0)*COLS_PER_CYCLE + k) -: 32]);
`endif
    end
  end

  // Stage p0: state register, step counter and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_p0    <= IDLE;
      cnt_p0    <= '0;
      data_p0   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_p0    <= 1'b0;
`endif
    end else begin
      case (fsm_p0)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_p0  <= in_state;
            cnt_p0   <= '0;
            in_ready <= 1'b0;
            fsm_p0   <= BUSY;
`ifdef MIXCOL_INV_EN
            inv_p0   <= in_inv;
`endif
          end
        end
        BUSY: begin
          data_p0 <= data_next;
          if (cnt_p0 == LAST_STEP) begin
            // Counter is parked at 0 so it never indexes past column 3.
            cnt_p0    <= '0;
            out_valid <= 1'b1;
            fsm_p0    <= DONE;
          end else begin
            cnt_p0 <= cnt_p0 + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm_p0    <= IDLE;
          end
        end
        default: begin
          fsm_p0    <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_state = data_p0;

endmodule

// File: tb/tb_mixcol_iter.sv
// ---------------------------------------------------------------------------
// tb_mixcol_iter
//
// Bench for mixcol_iter. Expected states come from a reference model that
// multiplies each column by the MixColumns / InvMixColumns coefficient matrix
// using a generic shift-and-add GF(2^8) multiplier. Timing expectations are
// derived from NSTEP = 4/CPC.
// ---------------------------------------------------------------------------
module tb_mixcol_iter #(
  parameter int CPC = 1
);

  localparam int NSTEP = 4 / CPC;
`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mixcol_iter #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Generic GF(2^8) product, polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix times each column; row r coefficient for input j is
  // base[(j - r) mod 4].
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv && INV_EN) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else               base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - r + 4) % 4], a[j]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts clocks until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
  endtask

  // Presents one state (DUT must be idle), returns the result and latency.
  task automatic do_xfer(input logic [127:0] st, input logic inv,
                         output logic [127:0] res, output int lat);
    in_state = st;
    in_inv   = inv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    res = out_state;
  endtask

  initial begin
    logic [127:0] res, exp, s1, s2, other;
    logic         inv;
    int           lat, hold;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("reset_in_ready",  128'(in_ready),  128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_state", out_state, '0);

    // Forward FIPS-197 vector.
    do_xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, res, lat);
    check("fwd_latency", 128'(lat), 128'(NSTEP));
    check("fwd_state", res, 128'h046681e5e0cb199a48f8d37a2806264c);
    check("fwd_busy_in_ready", 128'(in_ready), 128'(0));
    step();
    check("fwd_hs_out_valid", 128'(out_valid), 128'(0));
    check("fwd_hs_in_ready",  128'(in_ready),  128'(1));

    // Inverse vector; forward-only build must give the forward transform.
    do_xfer(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, res, lat);
    if (INV_EN) exp = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    else        exp = ref_mix(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0);
    check("inv_latency", 128'(lat), 128'(NSTEP));
    check("inv_state", res, exp);
    step();

    // Fixed columns with backpressure; in_valid during DONE must be ignored.
    out_ready = 1'b0;
    do_xfer(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, res, lat);
    check("bp_latency", 128'(lat), 128'(NSTEP));
    other    = {$urandom, $urandom, $urandom, $urandom};
    in_state = other;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_state_hold", out_state, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_out_valid", 128'(out_valid), 128'(0));
    check("bp_hs_in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("bp_accept", 128'(in_ready), 128'(0));
    wait_out(lat);
    check("bp_next_latency", 128'(lat), 128'(NSTEP));
    check("bp_next_state", out_state, ref_mix(other, 1'b0));
    step();

    // Reset one edge after the first BUSY edge.
    in_state = 128'h0123456789abcdeffedcba9876543210;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_out_valid", 128'(out_valid), 128'(0));
    check("rst_mid_in_ready", 128'(in_ready), 128'(1));
    check("rst_mid_out_state", out_state, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_mid_no_output", 128'(out_valid), 128'(0));
    end

    // Random states, random direction, random consumer stall.
    for (int i = 0; i < 16; i++) begin
      s1        = {$urandom, $urandom, $urandom, $urandom};
      inv       = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      do_xfer(s1, inv, res, lat);
      check("rand_latency", 128'(lat), 128'(NSTEP));
      check("rand_state", res, ref_mix(s1, inv));
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        step();
        check("rand_hold", out_state, res);
      end
      out_ready = 1'b1;
      step();
      check("rand_hs", 128'(out_valid), 128'(0));
    end

    // Back-to-back with in_valid held high.
    s1        = {$urandom, $urandom, $urandom, $urandom};
    s2        = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    in_inv    = 1'b0;
    in_state  = s1;
    in_valid  = 1'b1;
    step();
    in_state = s2;
    wait_out(lat);
    check("b2b_first_latency", 128'(lat), 128'(NSTEP));
    check("b2b_first_state", out_state, ref_mix(s1, 1'b0));
    step();
    check("b2b_hs_in_ready", 128'(in_ready), 128'(1));
    check("b2b_hs_out_valid", 128'(out_valid), 128'(0));
    step();
    check("b2b_second_accept", 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    wait_out(lat);
    check("b2b_second_latency", 128'(lat), 128'(NSTEP));
    check("b2b_second_state", out_state, ref_mix(s2, 1'b0));
    step();
    check("b2b_final_idle", 128'(in_ready), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
